// File: rtl/ex2_resp_checker.sv
// Response checker for the lec2 bitwise datapath: compares y against OP(a,b).
// Optional mismatch log FIFO enabled by EX2_CHK_MISMATCH_LOG_EN.
module ex2_resp_checker #(
  parameter int W     = 8,
  parameter int OP    = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [W-1:0]     ff_a,
  output logic [W-1:0]     ff_b,
  output logic [W-1:0]     ff_y,
  output logic             log_valid,
  input  logic             log_rd,
  output logic [3*W-1:0]   log_data,
  output logic             log_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             err_q, err_d;
  logic [W-1:0]     ffa_q, ffa_d;
  logic [W-1:0]     ffb_q, ffb_d;
  logic [W-1:0]     ffy_q, ffy_d;

  logic         acc;
  logic         start_ok;
  logic         mis;
  logic [W-1:0] exp_v;

  always_comb begin
    case (OP)
      1:       exp_v = a | b;
      2:       exp_v = a ^ b;
      3:       exp_v = ~(a & b);
      default: exp_v = a & b;
    endcase
  end

  assign acc      = in_valid & in_ready;
  assign start_ok = start & (state_q != RUN);
  assign mis      = (y != exp_v);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start)
          state_d = (num_vec == '0) ? DONE : RUN;
      end
      RUN: begin
        if (acc && rem_q == CNT_W'(1))
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN);
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
  end

  always_comb begin
    rem_d  = rem_q;
    pass_d = pass_q;
    fail_d = fail_q;
    err_d  = err_q;
    ffa_d  = ffa_q;
    ffb_d  = ffb_q;
    ffy_d  = ffy_q;
    if (start_ok) begin
      rem_d  = num_vec;
      pass_d = '0;
      fail_d = '0;
      err_d  = 1'b0;
      ffa_d  = '0;
      ffb_d  = '0;
      ffy_d  = '0;
    end else if (acc) begin
      rem_d = rem_q - CNT_W'(1);
      if (mis) begin
        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        err_d = 1'b1;
        // capture only the first failure of the run
        if (!err_q) begin
          ffa_d = a;
          ffb_d = b;
          ffy_d = y;
        end
      end else if (pass_q != '1) begin
        pass_d = pass_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= 1'b0;
      ffa_q  <= '0;
      ffb_q  <= '0;
      ffy_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      err_q  <= err_d;
      ffa_q  <= ffa_d;
      ffb_q  <= ffb_d;
      ffy_q  <= ffy_d;
    end
  end

  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign err      = err_q;
  assign ff_a     = ffa_q;
  assign ff_b     = ffb_q;
  assign ff_y     = ffy_q;

`ifdef EX2_CHK_MISMATCH_LOG_EN
  logic [3*W-1:0] mem_q [4];
  logic [3*W-1:0] mem_d [4];
  logic [1:0]     wp_q, wp_d;
  logic [1:0]     rp_q, rp_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           push, pop, full, push_ok;

  assign push    = acc & mis;
  assign pop     = log_rd & (cnt_q != 3'd0);
  assign full    = (cnt_q == 3'd4);
  // a pop frees the slot in the same edge, so full+pop still accepts
  assign push_ok = push & (~full | pop);

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (pop) rp_d = rp_q + 2'd1;
    if (push_ok) begin
      mem_d[wp_q] = {a, b, y};
      wp_d        = wp_q + 2'd1;
    end
    if (push_ok && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push_ok && pop) cnt_d = cnt_q - 3'd1;
    if (start_ok)                ovf_d = 1'b0;
    else if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign log_valid = (cnt_q != 3'd0);
  assign log_data  = log_valid ? mem_q[rp_q] : '0;
  assign log_ovf   = ovf_q;
`else
  logic unused_log_rd;
  assign unused_log_rd = log_rd;
  assign log_valid     = 1'b0;
  assign log_data      = '0;
  assign log_ovf       = 1'b0;
`endif

endmodule

// File: doc/ex2_resp_checker.md
Name: ex2_resp_checker

Overview:
- Sequential response checker for the 8-bit two-operand bitwise datapath exercised in lec2.
- Consumes a stream of (a, b, y) triples from the stimulus side and compares each y against the expected OP(a, b).
- Counts passes and failures and captures the first failing vector.
- Gives a synthesizable, self-checking end to the same a/b/y interface, for use on-board or in regression.

Parameters:
- W, 8: operand and result width.
- OP, 0: expected function. 0=AND, 1=OR, 2=XOR, 3=NAND.
- CNT_W, 16: width of the vector-count, pass and fail counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run of num_vec vectors.
- num_vec  in  CNT_W  number of vectors in the run; sampled on start.
- in_valid  in  1  triple on a/b/y is valid.
- in_ready  out  1  checker accepts the triple this cycle.
- a  in  W  operand a as applied to the DUT.
- b  in  W  operand b as applied to the DUT.
- y  in  W  DUT output for (a, b).
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start or rst.
- pass_cnt  out  CNT_W  matching vectors, saturating.
- fail_cnt  out  CNT_W  mismatching vectors, saturating.
- err  out  1  sticky; set on any mismatch in the run.
- ff_a, ff_b, ff_y  out  W each  first failing triple.
- log_valid  out  1  log FIFO non-empty.
- log_rd  in  1  pop log FIFO.
- log_data  out  3*W  {a,b,y} of oldest logged failure.
- log_ovf  out  1  sticky log-overflow flag.

Behaviour:
- Reset (synchronous, rst=1 at posedge), all of the following:
  - state=IDLE.
  - in_ready, busy, done, err, log_valid and log_ovf = 0.
  - pass_cnt, fail_cnt, ff_a/ff_b/ff_y and log_data = 0.
  - Internal remaining-count = 0; log FIFO emptied.
  - rst overrides everything, including rst asserted mid-run.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN, or DONE if num_vec=0.
  - RUN --last accept--> DONE.
  - DONE --start--> RUN, or DONE if num_vec=0.
- On start (IDLE or DONE):
  - Clear pass_cnt, fail_cnt, err, ff_* and log_ovf.
  - Load remaining=num_vec. Log FIFO is not cleared.
- start while in RUN is ignored.
- in_ready = 1 exactly when state=RUN (combinational from state).
- Accept = in_valid & in_ready. On each accept:
  - exp = OP(a, b) over W bits.
  - Match (y == exp): pass_cnt += 1.
  - Mismatch: fail_cnt += 1 and err <= 1. If err was 0 before this cycle, ff_a/ff_b/ff_y <= a/b/y.
  - remaining -= 1.
  - If remaining was 1: state <= DONE; in_ready drops next cycle.
- Counter update latency is 1 cycle: counts and err are visible the cycle after the accept.
- done=1 in DONE only; busy=1 in RUN only.
- Counters saturate at 2^CNT_W-1 and never wrap.
- in_valid outside RUN is ignored: no count, no log.
- OP values outside 0..3 behave as AND.

Optional Feature:
- Macro: EX2_CHK_MISMATCH_LOG_EN.
- Defined:
  - 4-entry FIFO; each mismatch pushes {a,b,y}.
  - If full, the entry is dropped and log_ovf <= 1.
  - log_valid = FIFO non-empty; log_data = head entry.
  - log_rd & log_valid pops at the clock edge.
  - A push and a pop in the same cycle on a full FIFO succeed, with no overflow.
  - log_rd while empty is ignored.
- Undefined:
  - No FIFO is built; log_valid, log_data and log_ovf are tied to 0.
  - log_rd is ignored.

Test Plan:
- OP=0, num_vec=3, triples (F0,00,00), (F0,FF,F0), (F0,AA,A0): done=1, pass_cnt=3, fail_cnt=0, err=0.
- OP=0, num_vec=3, second triple y=0F instead of F0: fail_cnt=1, err=1, ff_a=F0, ff_b=FF, ff_y=0F, pass_cnt=2.
- OP=2, num_vec=4, in_valid gapped (1,0,1,1,0,1): exactly 4 accepts, then in_ready=0. in_valid after done is not counted.
- start with num_vec=0: done=1 the next cycle, counters 0. start pulse during RUN: no effect on remaining or counts.
- rst asserted mid-run after 2 of 5 vectors: next cycle state IDLE, all outputs 0. A new start runs cleanly.
- With EX2_CHK_MISMATCH_LOG_EN, 6 mismatches and no reads: log_valid=1, log_ovf=1, 4 pops return the first 4 failures in order, then log_valid=0.
